load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Multi-cycle data-memory engine for the rv32i core. It consumes the decoder's load/store intent (is_store, funct3, effective address, store data) and runs one request/acknowledge transaction on a word-wide data-memory bus. It generates byte enables, aligns and replicates store data, and extracts and sign/zero-extends load data. It stalls the core through busy and signals completion with a one-cycle done pulse.

Parameters:
TIMEOUT, 15, maximum cycles to wait for mem_ack after mem_req rises; used only with LSU_TIMEOUT_EN.

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse to begin an access; sampled only in IDLE
is_store  input  1  1 = store (SB/SH/SW), 0 = load
funct3  input  3  instr[14:12]: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
addr  input  32  effective byte address (rs1 + imm)
wdata  input  32  rs2 value for stores
busy  output  1  high from the cycle after start until the cycle done is high, inclusive
done  output  1  one-cycle completion pulse
rdata  output  32  extended load result; valid while done=1, held until the next done
misalign_err  output  1  qualified by done; misaligned address or illegal funct3
bus_err  output  1  qualified by done; timeout abort
mem_req  output  1  bus request, held until mem_ack
mem_we  output  1  1 = write
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_be  output  4  byte-lane enables
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  responder completion; mem_rdata valid in the same cycle
mem_rdata  input  32  read word

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n.
- Reset: state IDLE. All outputs 0, including rdata and the mem_* signals.
- Reset asserted mid-transaction drops mem_req immediately. No done is produced for the aborted access.
- FSM states: IDLE, REQ, RESP.
- IDLE, start=1 with a legal, aligned access: register the request fields and go to REQ. mem_req=1 from the next cycle.
- IDLE, start=1 with an illegal or misaligned access: go to RESP with misalign_err=1. No bus activity.
- Illegal funct3 values:
  - loads: 011, 110, 111
  - stores: 011 and above
- Misalignment rules:
  - H/HU/SH with addr[0]=1
  - W/SW with addr[1:0]≠00
- REQ: mem_req, mem_we, mem_addr, mem_be and mem_wdata are held constant until mem_ack. On mem_ack, capture the result and go to RESP.
- RESP: done=1 for one cycle, then return to IDLE.
- Latency: start at cycle 0, mem_req from cycle 1, ack at cycle k≥1, done at cycle k+1. A zero-wait responder gives done at cycle 2.
- start while busy is ignored. mem_ack outside REQ is ignored.
- Byte enables and store data:
  - SB: mem_be = 0001 << addr[1:0]; wdata[7:0] replicated ×4.
  - SH: mem_be = 0011 or 1100 by addr[1]; wdata[15:0] replicated ×2.
  - SW: mem_be = 1111.
  - Loads: mem_be = 1111, mem_wdata = 0.
- Load extraction: select the byte by addr[1:0] or the halfword by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Stores leave rdata unchanged.

Optional Feature:
- LSU_TIMEOUT_EN defined: a counter is cleared on entry to REQ and increments each cycle without mem_ack. When it reaches TIMEOUT, mem_req drops and the FSM goes to RESP with bus_err=1 and rdata unchanged. An ack arriving in the same cycle as the timeout wins (normal completion).
- LSU_TIMEOUT_EN undefined: bus_err is tied 0 and REQ waits indefinitely.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - opcode constants OP_LOAD=0000011, OP_STORE=0100011
  - the state enum
- Sub-module lsu_load_align is purely combinational: (mem_rdata, addr[1:0], funct3) → 32-bit extended result.

Test Plan:
- LW addr=0x100, zero-wait responder returns 0xDEADBEEF → mem_addr=0x100, mem_be=1111, done at cycle 2, rdata=0xDEADBEEF.
- LB addr=0x103 with word 0x80FF1234; then LBU at the same address → rdata=0xFFFFFF80, then 0x00000080.
- SH addr=0x202, wdata=0x0000ABCD → mem_we=1, mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD.
- LW addr=0x101 → no mem_req; done at cycle 1 with misalign_err=1. funct3=011 load → same response.
- Responder delays ack 5 cycles; start pulses during the wait → mem_req stable for 5 cycles, extra starts ignored, exactly one done.
- LSU_TIMEOUT_EN defined, TIMEOUT=15, no ack → mem_req drops after 15 cycles, done with bus_err=1. Separately, rst_n pulsed low mid-REQ → mem_req=0 immediately, no done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the rv32i load/store unit: funct3 encodings,
// opcodes and the transaction FSM state type.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: selects the addressed byte/halfword from the
// fetched word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_HU:   result = {16'h0, half_sel};
      default: result = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory engine: one req/ack bus transaction per access.
// Define LSU_TIMEOUT_EN to abort unanswered requests after TIMEOUT cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        mis_q, mis_d;

  logic        legal, misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] load_result;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          berr_q, berr_d;
`endif

  lsu_load_align u_load_align (
    .mem_rdata (mem_rdata),
    .offset    (off_q),
    .funct3    (f3_q),
    .result    (load_result)
  );

  always_comb begin
    if (is_store) legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else          legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    // funct3[1:0]==01 covers both H and HU
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3 == F3_W) && (addr[1:0] != 2'b00));

    be_calc    = 4'b1111;
    wdata_calc = 32'h0;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          be_calc    = 4'b0001 << addr[1:0];
          wdata_calc = {4{wdata[7:0]}};
        end
        F3_H: begin
          be_calc    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_calc = {2{wdata[15:0]}};
        end
        default: wdata_calc = wdata;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    mis_d   = mis_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
    berr_d  = berr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef LSU_TIMEOUT_EN
          berr_d = 1'b0;
          cnt_d  = '0;
`endif
          if (!legal || misaligned) begin
            mis_d   = 1'b1;
            state_d = RESP;
          end else begin
            mis_d   = 1'b0;
            addr_d  = {addr[31:2], 2'b00};
            be_d    = be_calc;
            wdata_d = wdata_calc;
            we_d    = is_store;
            f3_d    = funct3;
            off_d   = addr[1:0];
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // an ack in the timeout cycle still completes normally
        if (mem_ack) begin
          if (!we_q) rdata_d = load_result;
          state_d = RESP;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          berr_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      mis_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
      berr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      mis_q   <= mis_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
`endif
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == RESP);
  assign mem_req      = (state_q == REQ);
  assign mem_we       = mem_req & we_q;
  assign mem_addr     = addr_q;
  assign mem_be       = be_q;
  assign mem_wdata    = wdata_q;
  assign rdata        = rdata_q;
  assign misalign_err = done & mis_q;
`ifdef LSU_TIMEOUT_EN
  assign bus_err      = done & berr_q;
`else
  assign bus_err      = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: loads, stores, alignment
// errors, wait states, ignored starts/acks, long waits and mid-access reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, misalign_err, bus_err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int failures = 0;
  int done_cyc, req_cycles, unstable, done_pulses;
  logic        req_s, we_s;
  logic [31:0] addr_s, wd_s;
  logic [3:0]  be_s;

  load_store_unit #(.TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .is_store     (is_store),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .rdata        (rdata),
    .misalign_err (misalign_err),
    .bus_err      (bus_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start one access, ack it in cycle ack_at (start is cycle 0) and return in
  // the done cycle. poke re-asserts start with different fields while waiting.
  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int ack_at, input logic [31:0] word,
                     input logic poke);
    is_store = st; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    step();
    start = 1'b0;
    req_s = mem_req; we_s = mem_we; addr_s = mem_addr; be_s = mem_be; wd_s = mem_wdata;
    done_cyc = 1; req_cycles = 0; unstable = 0;
    while (!done && done_cyc < 60) begin
      if (mem_req) begin
        req_cycles++;
        if ({mem_we, mem_addr, mem_be, mem_wdata} !== {we_s, addr_s, be_s, wd_s}) unstable++;
      end
      if (mem_req && done_cyc >= ack_at) begin
        mem_ack = 1'b1; mem_rdata = word;
      end else begin
        mem_rdata = 32'h5A5A_5A5A;
      end
      if (poke) begin
        start = 1'b1; is_store = ~st; addr = 32'h0000_0555; funct3 = 3'b000;
      end
      step();
      mem_ack = 1'b0; start = 1'b0;
      done_cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_ctrl", {busy, done, misalign_err, bus_err, mem_req, mem_we, mem_be}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // LW zero-wait
    txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
    chk("lw_req", req_s, 1);
    chk("lw_we", we_s, 0);
    chk("lw_addr", addr_s, 32'h0000_0100);
    chk("lw_be", be_s, 4'hF);
    chk("lw_wdata", wd_s, 32'h0);
    chk("lw_done_cyc", done_cyc, 2);
    chk("lw_done", done, 1);
    chk("lw_busy_in_done", busy, 1);
    chk("lw_rdata", rdata, 32'hDEAD_BEEF);
    chk("lw_errs", {misalign_err, bus_err}, 0);
    step();
    chk("lw_idle", {busy, done, mem_req}, 0);
    chk("lw_hold", rdata, 32'hDEAD_BEEF);

    // Sub-word loads from word 0x80FF1234
    txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234, 1'b0);
    chk("lb_addr", addr_s, 32'h0000_0100);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    step();
    txn(1'b0, 3'b100, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234, 1'b0);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    step();
    txn(1'b0, 3'b001, 32'h0000_0102, 32'h0, 1, 32'h80FF_1234, 1'b0);
    chk("lh_be", be_s, 4'hF);
    chk("lh_rdata", rdata, 32'hFFFF_80FF);
    step();
    txn(1'b0, 3'b101, 32'h0000_0100, 32'h0, 1, 32'h80FF_1234, 1'b0);
    chk("lhu_rdata", rdata, 32'h0000_1234);
    step();
    txn(1'b0, 3'b000, 32'h0000_0101, 32'h0, 1, 32'h80FF_1234, 1'b0);
    chk("lb_pos_rdata", rdata, 32'h0000_0012);
    step();

    // Stores
    txn(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 1, 32'h0, 1'b0);
    chk("sh_we", we_s, 1);
    chk("sh_addr", addr_s, 32'h0000_0200);
    chk("sh_be", be_s, 4'b1100);
    chk("sh_wdata", wd_s, 32'hABCD_ABCD);
    chk("sh_done_cyc", done_cyc, 2);
    chk("sh_rdata_kept", rdata, 32'h0000_0012);
    step();
    chk("sh_we_idle", mem_we, 0);
    txn(1'b1, 3'b000, 32'h0000_0101, 32'h1234_56EF, 1, 32'h0, 1'b0);
    chk("sb_be", be_s, 4'b0010);
    chk("sb_wdata", wd_s, 32'hEFEF_EFEF);
    step();
    txn(1'b1, 3'b010, 32'h0000_0300, 32'h0123_4567, 1, 32'h0, 1'b0);
    chk("sw_be", be_s, 4'hF);
    chk("sw_wdata", wd_s, 32'h0123_4567);
    step();

    // Misaligned / illegal accesses
    txn(1'b0, 3'b010, 32'h0000_0101, 32'h0, 1, 32'h0, 1'b0);
    chk("lw_mis_noreq", {req_s, 8'(req_cycles)}, 0);
    chk("lw_mis_done_cyc", done_cyc, 1);
    chk("lw_mis_err", {done, misalign_err, bus_err}, 3'b110);
    chk("lw_mis_rdata", rdata, 32'h0000_0012);
    step();
    chk("mis_err_cleared", {misalign_err, busy}, 0);
    txn(1'b0, 3'b011, 32'h0000_0100, 32'h0, 1, 32'h0, 1'b0);
    chk("ld_f3_011", {req_s, 8'(done_cyc), misalign_err}, {1'b0, 8'd1, 1'b1});
    step();
    txn(1'b1, 3'b100, 32'h0000_0100, 32'h0, 1, 32'h0, 1'b0);
    chk("st_f3_100", {req_s, 8'(done_cyc), misalign_err}, {1'b0, 8'd1, 1'b1});
    step();
    txn(1'b0, 3'b101, 32'h0000_0103, 32'h0, 1, 32'h0, 1'b0);
    chk("lhu_mis", {req_s, 8'(done_cyc), misalign_err}, {1'b0, 8'd1, 1'b1});
    step();

    // Five wait cycles with extra starts while busy
    txn(1'b0, 3'b010, 32'h0000_0104, 32'h0, 5, 32'hCAFE_F00D, 1'b1);
    chk("wait_req_cycles", req_cycles, 5);
    chk("wait_stable", unstable, 0);
    chk("wait_done_cyc", done_cyc, 6);
    chk("wait_rdata", rdata, 32'hCAFE_F00D);
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0100; start = 1'b1;
    step();
    start = 1'b0;
    chk("start_in_resp_ignored", {busy, done, mem_req}, 0);
    done_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || mem_req) done_pulses++;
      step();
    end
    chk("single_done", done_pulses, 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("ack_idle_ignored", {busy, done, mem_req}, 0);

`ifdef LSU_TIMEOUT_EN
    txn(1'b0, 3'b010, 32'h0000_0400, 32'h0, 1000, 32'h0, 1'b0);
    chk("to_req_cycles", req_cycles, 15);
    chk("to_done_cyc", done_cyc, 16);
    chk("to_bus_err", {done, bus_err, misalign_err}, 3'b110);
    chk("to_rdata_kept", rdata, 32'hCAFE_F00D);
    step();
    chk("to_idle", {busy, bus_err}, 0);
    txn(1'b0, 3'b010, 32'h0000_0400, 32'h0, 15, 32'h1357_2468, 1'b0);
    chk("to_ack_wins_cyc", done_cyc, 16);
    chk("to_ack_wins_err", bus_err, 0);
    chk("to_ack_wins_rdata", rdata, 32'h1357_2468);
    step();
`else
    txn(1'b0, 3'b010, 32'h0000_0400, 32'h0, 30, 32'h1357_2468, 1'b0);
    chk("long_req_cycles", req_cycles, 30);
    chk("long_done_cyc", done_cyc, 31);
    chk("long_bus_err", bus_err, 0);
    chk("long_rdata", rdata, 32'h1357_2468);
    step();
`endif

    // Reset in the middle of a request
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0500; start = 1'b1;
    step();
    start = 1'b0;
    chk("mid_rst_req_before", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_drop", {mem_req, busy, done}, 0);
    chk("mid_rst_rdata", rdata, 32'h0);
    step();
    step();
    @(negedge clk) rst_n = 1'b1;
    done_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done || mem_req) done_pulses++;
    end
    chk("mid_rst_no_done", done_pulses, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
